// File: rtl/cp0_unit_if.sv
//==============================================================================
// Module      : cp0_unit_if
// Description : Pipeline-side bus bundle for the coprocessor-0 exception
//               controller. It groups the mtc0/mfc0 port, the M-stage
//               exception inputs, and the redirect outputs returned to the
//               next-PC logic.
//   master : pipeline side. It drives WE/A1/A2/DIn/VPC/BDIn/ExcCodeIn/HWInt/EXLClr
//            and samples DOut/EPCOut/Req/HandlerPC.
//   slave  : cp0_unit side, which is the mirror image of master.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cp0_unit_if;
   logic        WE;         // mtc0 write enable
   logic [4:0]  A1;         // mfc0 read register number
   logic [4:0]  A2;         // mtc0 write register number
   logic [31:0] DIn;        // mtc0 write data
   logic [31:0] VPC;        // PC of the instruction in M
   logic        BDIn;       // M instruction is in a branch delay slot
   logic [4:0]  ExcCodeIn;  // exception code of M instruction, 0 = none
   logic [5:0]  HWInt;      // external interrupt lines
   logic        EXLClr;     // eret retiring in M
   logic [31:0] DOut;       // mfc0 read data
   logic [31:0] EPCOut;     // current EPC (eret target)
   logic        Req;        // redirect to handler this cycle
   logic [31:0] HandlerPC;  // exception entry PC

   modport master (
      output WE, A1, A2, DIn, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  DOut, EPCOut, Req, HandlerPC
   );

   modport slave (
      input  WE, A1, A2, DIn, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output DOut, EPCOut, Req, HandlerPC
   );
endinterface

`default_nettype wire

// File: rtl/cp0_unit.sv
//==============================================================================
// Module      : cp0_unit
// Description : Coprocessor-0 exception controller at the M stage. It detects
//               interrupts and exceptions, captures the victim PC into EPC,
//               and holds the SR, Cause and EPC registers.
//   clk   : single clock
//   reset : synchronous active-high reset
//   bus   : cp0_unit_if.slave
//             inputs  WE, A1, A2, DIn, VPC, BDIn, ExcCodeIn, HWInt, EXLClr
//             outputs DOut (mfc0 data, combinational), EPCOut (registered),
//                     Req (combinational), HandlerPC (constant)
// Config      : `define CP0_PRID_EN makes reg 15 read PRID_VALUE.
//               Without it, reg 15 reads 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cp0_unit #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VALUE   = 32'h2022_0700
) (
   input  wire logic   clk,
   input  wire logic   reset,
   cp0_unit_if.slave   bus
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // Only the architecturally defined fields are stored. Every other bit
   // reads back as zero.
   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc_q;

   logic        int_req;
   logic        exc_req;
   logic        req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] prid_word;
   logic [31:0] rd_data;

   // While EXL is set, all requests are masked. Interrupts are level-sensitive
   // and are never latched.
   assign int_req = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
   assign exc_req = (bus.ExcCodeIn != 5'd0) & ~sr_exl;
   assign req     = int_req | exc_req;

   assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

`ifdef CP0_PRID_EN
   assign prid_word = PRID_VALUE;
`else
   assign prid_word = 32'd0;
   // This keeps PRID_VALUE referenced when the feature is compiled out.
   logic unused_prid;
   assign unused_prid = ^PRID_VALUE;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'd0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc_q     <= 32'd0;
      end else begin
         // IP follows the interrupt lines on every edge.
         cause_ip <= bus.HWInt;
         if (req) begin
            // The faulting instruction does not retire. Any concurrent mtc0
            // and any concurrent eret are discarded.
            sr_exl    <= 1'b1;
            cause_bd  <= bus.BDIn;
            cause_exc <= int_req ? 5'd0 : bus.ExcCodeIn;
            epc_q     <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
         end else begin
            if (bus.EXLClr) begin
               sr_exl <= 1'b0;
            end
            if (bus.WE && (bus.A2 == REG_SR)) begin
               sr_im  <= bus.DIn[15:10];
               sr_exl <= bus.DIn[1];
               sr_ie  <= bus.DIn[0];
            end
            if (bus.WE && (bus.A2 == REG_EPC)) begin
               epc_q <= bus.DIn;
            end
         end
      end
   end

   // The read port shows state from before the edge. DIn is not bypassed.
   always_comb begin
      rd_data = 32'd0;
      case (bus.A1)
         REG_SR:    rd_data = sr_word;
         REG_CAUSE: rd_data = cause_word;
         REG_EPC:   rd_data = epc_q;
         REG_PRID:  rd_data = prid_word;
         default:   rd_data = 32'd0;
      endcase
   end

   assign bus.DOut      = rd_data;
   assign bus.EPCOut    = epc_q;
   assign bus.Req       = req;
   assign bus.HandlerPC = HANDLER_ADDR;

endmodule

`default_nettype wire
